// File: rtl/fcpu_pkg.sv
// fcpu_pkg: types and constants shared by the fcpu core.
// Adds the reorder-buffer entry record (rob_entry_t) and the derived
// reorder-buffer depth N_ROB. The payload widths of rob_entry_t follow the
// FCPU_* constants, so the ROB's DATA_W/REG_ADDR_W must keep those values.
package fcpu_pkg;

    localparam int FCPU_ROB_W      = 4;
    localparam int FCPU_DATA_W     = 32;
    localparam int FCPU_REG_ADDR_W = 5;
    localparam int N_ROB           = 2 ** FCPU_ROB_W;

    typedef enum logic [2:0] {
        commit_alu    = 3'd0,
        commit_load   = 3'd1,
        commit_store  = 3'd2,
        commit_branch = 3'd3,
        commit_jump   = 3'd4
    } commit_type_t;

    // 'type' is a keyword, so the commit class field is called ctype.
    typedef struct packed {
        logic                       valid;
        logic                       ready;
        logic                       mispredict;
        commit_type_t               ctype;
        logic [FCPU_REG_ADDR_W-1:0] dst;
        logic [FCPU_DATA_W-1:0]     data;
    } rob_entry_t;

endpackage

// File: rtl/fcpu_reorder_buffer_if.sv
// fcpu_reorder_buffer_if: bundle of the reorder buffer's dispatch, CDB,
// operand-lookup, commit and status signals.
//   master : the core side (dispatch, CDBs, reservation stations, retire).
//   slave  : the reorder buffer itself.
interface fcpu_reorder_buffer_if #(
    parameter int N_ROB_W    = 4,
    parameter int N_CDB      = 2,
    parameter int N_LOOKUP   = 2,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) ();
    logic                         disp_valid;
    logic                         disp_ready;
    logic [2:0]                   disp_type;
    logic [REG_ADDR_W-1:0]        disp_dst;
    logic [N_ROB_W-1:0]           disp_tag;

    logic [N_CDB-1:0]             cdb_valid;
    logic [N_CDB*N_ROB_W-1:0]     cdb_tag;
    logic [N_CDB*DATA_W-1:0]      cdb_data;
    logic [N_CDB-1:0]             cdb_mispredict;

    logic [N_LOOKUP*N_ROB_W-1:0]  lk_tag;
    logic [N_LOOKUP-1:0]          lk_ready;
    logic [N_LOOKUP*DATA_W-1:0]   lk_data;

    logic                         commit_valid;
    logic                         commit_ready;
    logic [2:0]                   commit_type;
    logic [REG_ADDR_W-1:0]        commit_dst;
    logic [DATA_W-1:0]            commit_data;
    logic [N_ROB_W-1:0]           commit_tag;

    logic                         flush;
    logic [N_ROB_W:0]             count;

    modport master (
        output disp_valid, disp_type, disp_dst,
        output cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
        output lk_tag, commit_ready,
        input  disp_ready, disp_tag, lk_ready, lk_data,
        input  commit_valid, commit_type, commit_dst, commit_data, commit_tag,
        input  flush, count
    );

    modport slave (
        input  disp_valid, disp_type, disp_dst,
        input  cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
        input  lk_tag, commit_ready,
        output disp_ready, disp_tag, lk_ready, lk_data,
        output commit_valid, commit_type, commit_dst, commit_data, commit_tag,
        output flush, count
    );
endinterface

// File: rtl/fcpu_rob_cdb_merge.sv
// fcpu_rob_cdb_merge: folds the N_CDB result channels into per-entry write
// enable, data and mispredict vectors. When several channels carry the same
// tag, the lowest channel index wins.
//   cdb_*         : flattened per-channel CDB inputs
//   wr_en         : entry is addressed by some channel this cycle
//   wr_data       : winning channel's data per entry
//   wr_mispredict : winning channel's mispredict flag per entry
module fcpu_rob_cdb_merge #(
    parameter int N_ROB_W = 4,
    parameter int N_CDB   = 2,
    parameter int DATA_W  = 32
) (
    input  logic [N_CDB-1:0]                        cdb_valid,
    input  logic [N_CDB*N_ROB_W-1:0]                cdb_tag,
    input  logic [N_CDB*DATA_W-1:0]                 cdb_data,
    input  logic [N_CDB-1:0]                        cdb_mispredict,
    output logic [2**N_ROB_W-1:0]                   wr_en,
    output logic [2**N_ROB_W-1:0][DATA_W-1:0]       wr_data,
    output logic [2**N_ROB_W-1:0]                   wr_mispredict
);
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        wr_en         = '0;
        wr_data       = '0;
        wr_mispredict = '0;
        // Walk from the highest channel down so lower channels overwrite.
        for (int c = N_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c]) begin
                wr_en[cdb_tag[c*N_ROB_W +: N_ROB_W]]         = 1'b1;
                wr_data[cdb_tag[c*N_ROB_W +: N_ROB_W]]       = cdb_data[c*DATA_W +: DATA_W];
                wr_mispredict[cdb_tag[c*N_ROB_W +: N_ROB_W]] = cdb_mispredict[c];
            end
        end
    end
endmodule

// File: rtl/fcpu_reorder_buffer.sv
// fcpu_reorder_buffer: in-order allocate / out-of-order complete / in-order
// retire buffer of 2**N_ROB_W entries for the fcpu core.
//   clk, rst_n : clock, synchronous active-low reset
//   rob        : slave side of fcpu_reorder_buffer_if (dispatch, CDB writes,
//                operand lookup, commit, flush pulse, occupancy count)
// Build option: FCPU_ROB_CDB_BYPASS_EN makes the lookup ports also see the
// CDB broadcasts of the current cycle.
module fcpu_reorder_buffer
    import fcpu_pkg::*;
#(
    parameter int N_ROB_W    = FCPU_ROB_W,
    parameter int N_CDB      = 2,
    parameter int N_LOOKUP   = 2,
    parameter int DATA_W     = FCPU_DATA_W,
    parameter int REG_ADDR_W = FCPU_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fcpu_reorder_buffer_if.slave  rob
);
    localparam int DEPTH = 2 ** N_ROB_W;
    typedef logic [N_ROB_W:0] ptr_t;

    rob_entry_t          rob_q [DEPTH];
    ptr_t                head_q, tail_q;
    logic                flush_q;

    logic [N_ROB_W-1:0]  head_idx, tail_idx;
    logic                full, disp_fire, commit_fire, commit_ok;
    rob_entry_t          head_e;

    logic [DEPTH-1:0]              wr_en, wr_mispredict;
    logic [DEPTH-1:0][DATA_W-1:0]  wr_data;

    fcpu_rob_cdb_merge #(.N_ROB_W(N_ROB_W), .N_CDB(N_CDB), .DATA_W(DATA_W)) u_merge (
        .cdb_valid      (rob.cdb_valid),
        .cdb_tag        (rob.cdb_tag),
        .cdb_data       (rob.cdb_data),
        .cdb_mispredict (rob.cdb_mispredict),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .wr_mispredict  (wr_mispredict)
    );

    assign head_idx = head_q[N_ROB_W-1:0];
    assign tail_idx = tail_q[N_ROB_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[N_ROB_W] != tail_q[N_ROB_W]);
    assign head_e   = rob_q[head_idx];

    // Both handshakes look at registered state only; a flush cycle blocks both.
    assign commit_ok   = head_e.valid && head_e.ready && !flush_q;
    assign commit_fire = commit_ok && rob.commit_ready;
    assign disp_fire   = rob.disp_valid && rob.disp_ready;

    assign rob.disp_ready   = !full && !flush_q;
    assign rob.disp_tag     = tail_idx;
    assign rob.commit_valid = commit_ok;
    assign rob.commit_tag   = head_idx;
    // Payload is masked so stale data of a retired slot never shows.
    assign rob.commit_type  = commit_ok ? head_e.ctype : 3'd0;
    assign rob.commit_dst   = commit_ok ? head_e.dst   : '0;
    assign rob.commit_data  = commit_ok ? head_e.data  : '0;
    assign rob.flush        = flush_q;
    assign rob.count        = tail_q - head_q;

    always_comb begin
        rob.lk_ready = '0;
        rob.lk_data  = '0;
        for (int l = 0; l < N_LOOKUP; l++) begin
            if (rob_q[rob.lk_tag[l*N_ROB_W +: N_ROB_W]].valid &&
                rob_q[rob.lk_tag[l*N_ROB_W +: N_ROB_W]].ready) begin
                rob.lk_ready[l]                = 1'b1;
                rob.lk_data[l*DATA_W +: DATA_W] = rob_q[rob.lk_tag[l*N_ROB_W +: N_ROB_W]].data;
            end
`ifdef FCPU_ROB_CDB_BYPASS_EN
            // The merged CDB view already carries the lowest-channel winner.
            if (!flush_q && rob_q[rob.lk_tag[l*N_ROB_W +: N_ROB_W]].valid &&
                wr_en[rob.lk_tag[l*N_ROB_W +: N_ROB_W]]) begin
                rob.lk_ready[l]                = 1'b1;
                rob.lk_data[l*DATA_W +: DATA_W] = wr_data[rob.lk_tag[l*N_ROB_W +: N_ROB_W]];
            end
`endif
        end
    end

    // NOTE: all state here uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_q) begin
            head_q  <= '0;
            tail_q  <= '0;
            flush_q <= 1'b0;
            // NOTE: only the control bits are cleared; payload is don't-care while valid=0.
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i].valid      <= 1'b0;
                rob_q[i].ready      <= 1'b0;
                rob_q[i].mispredict <= 1'b0;
            end
        end else begin
            flush_q <= commit_fire && (head_e.ctype == commit_branch) && head_e.mispredict;

            // The slot being dispatched is still invalid here, so CDB writes to it drop out.
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i] && rob_q[i].valid) begin
                    rob_q[i].ready <= 1'b1;
                    rob_q[i].data  <= wr_data[i];
                    if (wr_mispredict[i]) rob_q[i].mispredict <= 1'b1;
                end
            end

            if (commit_fire) begin
                rob_q[head_idx].valid      <= 1'b0;
                rob_q[head_idx].ready      <= 1'b0;
                rob_q[head_idx].mispredict <= 1'b0;
                head_q                     <= head_q + ptr_t'(1);
            end

            if (disp_fire) begin
                rob_q[tail_idx].valid      <= 1'b1;
                rob_q[tail_idx].ready      <= 1'b0;
                rob_q[tail_idx].mispredict <= 1'b0;
                rob_q[tail_idx].ctype      <= commit_type_t'(rob.disp_type);
                rob_q[tail_idx].dst        <= rob.disp_dst;
                tail_q                     <= tail_q + ptr_t'(1);
            end
        end
    end
endmodule

// File: tb/tb_fcpu_reorder_buffer.sv
// tb_fcpu_reorder_buffer: directed self-checking bench for fcpu_reorder_buffer.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1-2 units
// after the edge, well before the next one.
module tb_fcpu_reorder_buffer;
    import fcpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef FCPU_ROB_CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    fcpu_reorder_buffer_if rif ();
    fcpu_reorder_buffer dut (.clk(clk), .rst_n(rst_n), .rob(rif));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rif.disp_valid     = 1'b0;
        rif.disp_type      = 3'd0;
        rif.disp_dst       = '0;
        rif.cdb_valid      = '0;
        rif.cdb_tag        = '0;
        rif.cdb_data       = '0;
        rif.cdb_mispredict = '0;
        rif.lk_tag         = '0;
        rif.commit_ready   = 1'b0;
    endtask

    task automatic cdb(input int ch, input int tag, input logic [31:0] data, input logic misp);
        rif.cdb_valid[ch]          = 1'b1;
        rif.cdb_tag[ch*4 +: 4]     = 4'(tag);
        rif.cdb_data[ch*32 +: 32]  = data;
        rif.cdb_mispredict[ch]     = misp;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic dispatch(input int n, input logic [2:0] typ);
        for (int i = 0; i < n; i++) begin
            rif.disp_valid = 1'b1;
            rif.disp_type  = typ;
            rif.disp_dst   = 5'(i + 1);
            tick();
        end
        rif.disp_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (rif.disp_ready !== 1'b1) begin errors++; $display("FAIL reset_disp_ready got %0b want 1", rif.disp_ready); end
        checks++; if (rif.commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got %0b want 0", rif.commit_valid); end
        checks++; if (rif.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", rif.count); end
        checks++; if (rif.disp_tag !== 4'd0 || rif.commit_tag !== 4'd0) begin errors++; $display("FAIL reset_tags got %0d/%0d want 0/0", rif.disp_tag, rif.commit_tag); end
        checks++; if (rif.commit_data !== 32'd0 || rif.commit_dst !== 5'd0 || rif.commit_type !== 3'd0) begin errors++; $display("FAIL reset_payload got %0h want 0", rif.commit_data); end
        checks++; if (rif.flush !== 1'b0 || rif.lk_ready !== 2'b00) begin errors++; $display("FAIL reset_flush_lk got %0b/%0b want 0/00", rif.flush, rif.lk_ready); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rif.disp_valid = 1'b1;
            rif.disp_type  = commit_alu;
            rif.disp_dst   = 5'(i);
            #1;
            checks++; if (rif.disp_tag !== 4'(i) || rif.disp_ready !== 1'b1) begin errors++; $display("FAIL fill_tag got %0d rdy %0b want %0d rdy 1", rif.disp_tag, rif.disp_ready, i); end
            tick();
        end
        checks++; if (rif.count !== 5'd16 || rif.disp_ready !== 1'b0) begin errors++; $display("FAIL fill_full got count %0d rdy %0b want 16 rdy 0", rif.count, rif.disp_ready); end
        tick();  // 17th request still held valid
        rif.disp_valid = 1'b0;
        checks++; if (rif.count !== 5'd16 || rif.commit_valid !== 1'b0) begin errors++; $display("FAIL fill_17th got count %0d cv %0b want 16 cv 0", rif.count, rif.commit_valid); end
    endtask

    task automatic test_in_order();
        do_reset();
        dispatch(3, commit_alu);
        cdb(0, 2, 32'h2A, 1'b0);
        tick();
        cdb(0, 0, 32'h10, 1'b0);
        #1;
        checks++; if (rif.commit_valid !== 1'b0) begin errors++; $display("FAIL order_wait got cv %0b want 0", rif.commit_valid); end
        tick();
        idle();
        #1;
        checks++; if (rif.commit_valid !== 1'b1 || rif.commit_tag !== 4'd0 || rif.commit_data !== 32'h10 || rif.commit_dst !== 5'd1)
            begin errors++; $display("FAIL order_c0 got cv %0b tag %0d data %0h dst %0d want 1 0 10 1", rif.commit_valid, rif.commit_tag, rif.commit_data, rif.commit_dst); end
        rif.commit_ready = 1'b1;
        tick();
        checks++; if (rif.commit_valid !== 1'b0 || rif.count !== 5'd2) begin errors++; $display("FAIL order_block got cv %0b count %0d want 0 2", rif.commit_valid, rif.count); end
        rif.commit_ready = 1'b0;
        cdb(0, 1, 32'h11, 1'b0);
        tick();
        idle();
        checks++; if (rif.commit_valid !== 1'b1 || rif.commit_tag !== 4'd1 || rif.commit_data !== 32'h11)
            begin errors++; $display("FAIL order_c1 got cv %0b tag %0d data %0h want 1 1 11", rif.commit_valid, rif.commit_tag, rif.commit_data); end
        rif.commit_ready = 1'b1;
        tick();
        checks++; if (rif.commit_valid !== 1'b1 || rif.commit_tag !== 4'd2 || rif.commit_data !== 32'h2A)
            begin errors++; $display("FAIL order_c2 got cv %0b tag %0d data %0h want 1 2 2a", rif.commit_valid, rif.commit_tag, rif.commit_data); end
        tick();
        rif.commit_ready = 1'b0;
        checks++; if (rif.commit_valid !== 1'b0 || rif.count !== 5'd0) begin errors++; $display("FAIL order_empty got cv %0b count %0d want 0 0", rif.commit_valid, rif.count); end
    endtask

    task automatic test_cdb_priority();
        logic [31:0] exp_data [4];
        exp_data = '{32'h100, 32'h101, 32'h102, 32'hAAAA};
        do_reset();
        dispatch(4, commit_alu);
        cdb(0, 3, 32'hAAAA, 1'b0);
        cdb(1, 3, 32'hBBBB, 1'b0);
        tick();
        idle();
        cdb(0, 0, 32'h100, 1'b0);
        cdb(1, 1, 32'h101, 1'b0);
        tick();
        idle();
        cdb(0, 2, 32'h102, 1'b0);
        rif.lk_tag[7:4] = 4'd3;
        tick();
        idle();
        rif.lk_tag[7:4] = 4'd3;
        #1;
        checks++; if (rif.lk_ready[1] !== 1'b1 || rif.lk_data[63:32] !== 32'hAAAA) begin errors++; $display("FAIL prio_lookup got %0b %0h want 1 aaaa", rif.lk_ready[1], rif.lk_data[63:32]); end
        rif.commit_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rif.commit_valid !== 1'b1 || rif.commit_tag !== 4'(i) || rif.commit_data !== exp_data[i])
                begin errors++; $display("FAIL prio_commit%0d got cv %0b tag %0d data %0h want 1 %0d %0h", i, rif.commit_valid, rif.commit_tag, rif.commit_data, i, exp_data[i]); end
            tick();
        end
        rif.commit_ready = 1'b0;
    endtask

    task automatic test_mispredict();
        do_reset();
        dispatch(1, commit_alu);
        dispatch(1, commit_branch);
        dispatch(4, commit_alu);
        cdb(0, 0, 32'h1, 1'b0);
        cdb(1, 1, 32'h2, 1'b1);
        tick();
        cdb(0, 2, 32'h3, 1'b0);
        cdb(1, 3, 32'h4, 1'b0);
        tick();
        cdb(0, 4, 32'h5, 1'b0);
        cdb(1, 5, 32'h6, 1'b0);
        tick();
        idle();
        rif.commit_ready = 1'b1;
        tick();  // tag 0 retires
        checks++; if (rif.commit_valid !== 1'b1 || rif.commit_tag !== 4'd1 || rif.commit_type !== 3'(commit_branch) || rif.flush !== 1'b0)
            begin errors++; $display("FAIL misp_branch got cv %0b tag %0d type %0d flush %0b want 1 1 3 0", rif.commit_valid, rif.commit_tag, rif.commit_type, rif.flush); end
        tick();  // branch retires
        checks++; if (rif.flush !== 1'b1 || rif.commit_valid !== 1'b0 || rif.disp_ready !== 1'b0)
            begin errors++; $display("FAIL misp_flush got flush %0b cv %0b dr %0b want 1 0 0", rif.flush, rif.commit_valid, rif.disp_ready); end
        rif.disp_valid = 1'b1;
        cdb(0, 2, 32'h99, 1'b0);
        tick();  // flush cycle: both requests must be dropped
        idle();
        checks++; if (rif.flush !== 1'b0 || rif.count !== 5'd0 || rif.disp_tag !== 4'd0 || rif.commit_valid !== 1'b0)
            begin errors++; $display("FAIL misp_after got flush %0b count %0d tag %0d cv %0b want 0 0 0 0", rif.flush, rif.count, rif.disp_tag, rif.commit_valid); end
        dispatch(1, commit_alu);
        checks++; if (rif.count !== 5'd1 || rif.commit_valid !== 1'b0 || rif.disp_tag !== 4'd1)
            begin errors++; $display("FAIL misp_redisp got count %0d cv %0b tag %0d want 1 0 1", rif.count, rif.commit_valid, rif.disp_tag); end
    endtask

    task automatic test_wrap();
        do_reset();
        dispatch(3, commit_alu);
        cdb(0, 0, 32'h1000, 1'b0);
        cdb(1, 1, 32'h1001, 1'b0);
        tick();
        idle();
        cdb(0, 2, 32'h1002, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 40; i++) begin
            rif.disp_valid   = 1'b1;
            rif.disp_type    = commit_alu;
            rif.commit_ready = 1'b1;
            cdb(0, (i + 2) % 16, 32'h1000 + 32'(i + 2), 1'b0);
            #1;
            checks++; if (rif.disp_tag !== 4'((i + 3) % 16) || rif.disp_ready !== 1'b1) begin errors++; $display("FAIL wrap_disp%0d got %0d want %0d", i, rif.disp_tag, (i + 3) % 16); end
            checks++; if (rif.commit_valid !== 1'b1 || rif.commit_tag !== 4'(i % 16) || rif.commit_data !== 32'h1000 + 32'(i))
                begin errors++; $display("FAIL wrap_commit%0d got cv %0b tag %0d data %0h want 1 %0d %0h", i, rif.commit_valid, rif.commit_tag, rif.commit_data, i % 16, 32'h1000 + i); end
            checks++; if (rif.count !== 5'd3) begin errors++; $display("FAIL wrap_count%0d got %0d want 3", i, rif.count); end
            tick();
        end
        idle();
    endtask

    task automatic test_lookup_and_reset();
        do_reset();
        dispatch(5, commit_alu);
        rif.lk_tag = {4'd0, 4'd4};
        cdb(0, 0, 32'h55, 1'b0);
        cdb(1, 4, 32'h77, 1'b0);
        #1;
        checks++; if (rif.lk_ready[0] !== BYPASS || rif.lk_data[31:0] !== (BYPASS ? 32'h77 : 32'h0))
            begin errors++; $display("FAIL lk_same got %0b %0h want %0b %0h", rif.lk_ready[0], rif.lk_data[31:0], BYPASS, BYPASS ? 32'h77 : 32'h0); end
        tick();
        rif.cdb_valid = '0;
        #1;
        checks++; if (rif.lk_ready !== 2'b11 || rif.lk_data !== {32'h55, 32'h77})
            begin errors++; $display("FAIL lk_next got %0b %0h want 11 %0h", rif.lk_ready, rif.lk_data, {32'h55, 32'h77}); end
        checks++; if (rif.commit_valid !== 1'b1) begin errors++; $display("FAIL lk_pending got cv %0b want 1", rif.commit_valid); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (rif.count !== 5'd0 || rif.commit_valid !== 1'b0 || rif.lk_ready !== 2'b00 || rif.disp_ready !== 1'b1)
            begin errors++; $display("FAIL mid_reset got count %0d cv %0b lk %0b dr %0b want 0 0 00 1", rif.count, rif.commit_valid, rif.lk_ready, rif.disp_ready); end
        idle();
    endtask

    initial begin
        idle();
        #1;
        test_reset();
        test_fill();
        test_in_order();
        test_cdb_priority();
        test_mispredict();
        test_wrap();
        test_lookup_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/fcpu_reorder_buffer.md
Name: fcpu_reorder_buffer

Overview:
Parametrised reorder buffer for the out-of-order fcpu core. It allocates one entry per dispatched instruction in program order and captures results from N_CDB common data buses. It retires entries in order to the register file and store path, and flushes everything on a committed branch mispredict. Supports depth 2**N_ROB_W, multiple CDB write channels and operand lookup ports for the reservation stations.

Parameters:
N_ROB_W, 4, log2 of entry count (depth 16 at default)
N_CDB, 2, number of CDB write channels
N_LOOKUP, 2, number of operand lookup ports
DATA_W, 32, result width
REG_ADDR_W, 5, architectural register index width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
disp_valid  in  1  dispatch request
disp_ready  out  1  entry available
disp_type  in  3  commit_type_t of instruction
disp_dst  in  REG_ADDR_W  destination register
disp_tag  out  N_ROB_W  tag allocated to current dispatch (valid when disp_valid&disp_ready)
cdb_valid  in  N_CDB  per-channel result valid
cdb_tag  in  N_CDB*N_ROB_W  per-channel ROB tag
cdb_data  in  N_CDB*DATA_W  per-channel result
cdb_mispredict  in  N_CDB  per-channel branch mispredict flag
lk_tag  in  N_LOOKUP*N_ROB_W  lookup tags
lk_ready  out  N_LOOKUP  entry valid and result present
lk_data  out  N_LOOKUP*DATA_W  entry result
commit_valid  out  1  head entry ready to retire
commit_ready  in  1  consumer accepts
commit_type  out  3  head commit_type_t
commit_dst  out  REG_ADDR_W  head destination
commit_data  out  DATA_W  head result
commit_tag  out  N_ROB_W  head tag
flush  out  1  one-cycle pipeline flush pulse
count  out  N_ROB_W+1  occupied entries

Behaviour:
- Circular buffer; head/tail pointers N_ROB_W+1 bits including a wrap bit. Full = indices equal and wrap bits differ; empty = pointers equal.
- Reset (rst_n low at posedge): head=tail=0, all entry valid/ready/mispredict cleared, flush=0, count=0. Reset mid-operation discards all entries with no commit. Outputs after reset: disp_ready=1, commit_valid=0, lk_ready=0, disp_tag=0, commit_tag=0, commit_* payload=0.
- Dispatch: disp_ready = !full, from registered state only, with no same-cycle commit bypass. On handshake the entry at tail is written with valid=1, ready=0, type and dst, and tail increments. disp_tag = tail index (combinational).
- CDB write: for each channel with cdb_valid whose tag addresses a valid entry, set ready=1, store data and OR in mispredict. Writes to invalid entries are ignored. When two channels hit the same tag in one cycle, the lower channel index wins. A write to a tag being dispatched in the same cycle is ignored.
- Commit: commit_valid = head entry valid & ready & !flush. On commit_valid&commit_ready the head is cleared and head increments. Latency: a CDB write at cycle N makes commit_valid visible at N+1 at the earliest.
- Mispredict: if the committing entry has type commit_branch and mispredict=1, flush=1 in the next cycle, for exactly one cycle. In that same flush cycle all entries are cleared, head=tail=0, and dispatch and CDB writes are ignored (disp_ready=0 during flush).
- Simultaneous dispatch and commit: both take effect and count is unchanged.
- Lookup: lk_ready/lk_data are read combinationally from registered entry state. An invalid entry gives lk_ready=0 and lk_data=0.

Optional Feature:
FCPU_ROB_CDB_BYPASS_EN
- Defined: the lookup ports also match the current-cycle CDB channels (lowest channel index first). A hit returns lk_ready=1 with the CDB data in the same cycle as the broadcast.
- Undefined: lookup reflects registered state only, and results become visible the cycle after the broadcast.

Decomposition:
- fcpu_pkg gains rob_entry_t (valid, ready, mispredict, commit_type_t type, dst, data) and a derived constant N_ROB = 2**N_ROB_W. commit_type_t already lives in fcpu_pkg.
- One sub-module, fcpu_rob_cdb_merge: priority-resolves the N_CDB channels into per-entry write enable, data and mispredict vectors.

Test Plan:
- Dispatch 16 entries with no CDB traffic -> tags 0..15, disp_ready=0 after the 16th, count=16; a 17th disp_valid is not accepted.
- Dispatch tags 0,1,2; CDB writes tag 2=0x2A, then tag 0=0x10 -> commit_valid only after tag 0 is ready; commits occur in order 0,1,2 once tag 1 is written.
- Channels 0 and 1 write tag 3 with 0xAAAA and 0xBBBB in the same cycle -> commit_data for tag 3 = 0xAAAA.
- Branch at tag 1 written with cdb_mispredict=1, younger tags 2..5 ready -> tag 1 commits, flush pulses for one cycle, count=0, next dispatch gets tag 0.
- Wrap-around: 40 dispatch/commit pairs at full throughput -> tags cycle 0..15 correctly and count stays constant.
- Lookup tag 4 in the same cycle as CDB writes 0x77 -> lk_ready=1 in that cycle with the macro defined, 1 cycle later without; assert rst_n=0 mid-stream -> count=0, commit_valid=0.
